// File: rtl/hash_table_probe.sv
// hash_table_probe: key/value store using open addressing with linear probing.
// Deletes leave tombstones. Requests use a valid/ready handshake and results
// come back as a one-cycle response pulse with a status code. One slot is
// probed per cycle, and the table changes only in the response cycle.
// Optional feature macro: HT_STATS_EN (adds hit_count / miss_count outputs).
module hash_table_probe #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int TABLE_SIZE  = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int MAX_PROBE   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [1:0]             op_code,
    input  logic [KEY_WIDTH-1:0]   op_key,
    input  logic [VALUE_WIDTH-1:0] op_value,
    output logic                   resp_valid,
    output logic                   resp_found,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic [1:0]             resp_status,
    output logic [INDEX_WIDTH:0]   count
`ifdef HT_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;

    localparam int NUM_CHUNKS = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
    localparam int PAD_WIDTH  = NUM_CHUNKS * INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] LAST_PROBE = (INDEX_WIDTH+1)'(MAX_PROBE - 1);

    typedef enum logic [1:0] {IDLE, PROBE, RESP} state_t;

    state_t state_reg, state_next;

    // Slot storage. Keys and values are not cleared by reset; the valid and
    // tombstone bits alone decide what each slot holds.
    logic [KEY_WIDTH-1:0]   key_mem [TABLE_SIZE];
    logic [VALUE_WIDTH-1:0] val_mem [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]  valid_reg;
    logic [TABLE_SIZE-1:0]  tomb_reg;

    // Request latched at accept.
    logic [KEY_WIDTH-1:0]   key_reg;
    logic [VALUE_WIDTH-1:0] value_reg;
    logic [1:0]             op_reg;
    logic [INDEX_WIDTH-1:0] hash_reg;
    logic [INDEX_WIDTH:0]   probe_k_reg;
    logic                   free_seen_reg;
    logic [INDEX_WIDTH-1:0] free_idx_reg;

    // Table update decided at the end of the probe and applied in RESP.
    logic                   act_wr_kv_reg;   // new entry: key, value, valid
    logic                   act_wr_v_reg;    // in-place value update
    logic                   act_del_reg;     // convert entry to tombstone
    logic [INDEX_WIDTH-1:0] act_idx_reg;

    logic                   accept;
    logic [PAD_WIDTH-1:0]   key_pad;
    logic [INDEX_WIDTH-1:0] chunk [NUM_CHUNKS];
    logic [INDEX_WIDTH-1:0] hash;

    logic [INDEX_WIDTH-1:0] slot;
    logic                   slot_valid;
    logic                   slot_empty;
    logic                   slot_match;
    logic                   probe_done;
    logic                   free_avail;
    logic [INDEX_WIDTH-1:0] free_idx;
    logic                   is_insert;
    logic                   is_delete;

    assign accept   = op_valid && op_ready;
    assign key_pad  = PAD_WIDTH'(op_key);

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
            assign chunk[gi] = key_pad[gi*INDEX_WIDTH +: INDEX_WIDTH];
        end
    endgenerate

    // XOR fold of the key into one slot index.
    always_comb begin
        hash = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            hash = hash ^ chunk[i];
        end
    end

    // Examine the current probe slot. An index wraps naturally at TABLE_SIZE.
    always_comb begin
        slot       = hash_reg + probe_k_reg[INDEX_WIDTH-1:0];
        slot_valid = valid_reg[slot];
        slot_empty = !valid_reg[slot] && !tomb_reg[slot];
        slot_match = slot_valid && (key_mem[slot] == key_reg);
        probe_done = slot_match || slot_empty || (probe_k_reg == LAST_PROBE);
        free_avail = free_seen_reg || !slot_valid;
        free_idx   = free_seen_reg ? free_idx_reg : slot;
        is_insert  = (op_reg == OP_INSERT);
        is_delete  = (op_reg == OP_DELETE);
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_next = PROBE;
            end
            PROBE: begin
                if (probe_done) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Request capture, probe bookkeeping, response registers and table flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= '0;
            tomb_reg      <= '0;
            count         <= '0;
            resp_found    <= 1'b0;
            resp_value    <= '0;
            resp_status   <= ST_OK;
            key_reg       <= '0;
            value_reg     <= '0;
            op_reg        <= '0;
            hash_reg      <= '0;
            probe_k_reg   <= '0;
            free_seen_reg <= 1'b0;
            free_idx_reg  <= '0;
            act_wr_kv_reg <= 1'b0;
            act_wr_v_reg  <= 1'b0;
            act_del_reg   <= 1'b0;
            act_idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        key_reg       <= op_key;
                        value_reg     <= op_value;
                        op_reg        <= op_code;
                        hash_reg      <= hash;
                        probe_k_reg   <= '0;
                        free_seen_reg <= 1'b0;
                    end
                end
                PROBE: begin
                    probe_k_reg <= probe_k_reg + 1'b1;
                    if (!slot_valid && !free_seen_reg) begin
                        free_seen_reg <= 1'b1;
                        free_idx_reg  <= slot;
                    end
                    if (probe_done) begin
                        act_wr_kv_reg <= 1'b0;
                        act_wr_v_reg  <= 1'b0;
                        act_del_reg   <= 1'b0;
                        act_idx_reg   <= slot;
                        if (slot_match) begin
                            resp_found   <= 1'b1;
                            resp_value   <= val_mem[slot];
                            resp_status  <= ST_OK;
                            act_wr_v_reg <= is_insert;
                            act_del_reg  <= is_delete;
                        end else begin
                            resp_found <= 1'b0;
                            resp_value <= '0;
                            if (is_insert) begin
                                if (free_avail) begin
                                    resp_status   <= ST_OK;
                                    act_wr_kv_reg <= 1'b1;
                                    act_idx_reg   <= free_idx;
                                end else begin
                                    resp_status <= ST_FULL;
                                end
                            end else begin
                                resp_status <= ST_NOT_FOUND;
                            end
                        end
                    end
                end
                RESP: begin
                    if (act_wr_kv_reg) begin
                        valid_reg[act_idx_reg] <= 1'b1;
                        tomb_reg[act_idx_reg]  <= 1'b0;
                        count                  <= count + 1'b1;
                    end
                    if (act_del_reg) begin
                        valid_reg[act_idx_reg] <= 1'b0;
                        tomb_reg[act_idx_reg]  <= 1'b1;
                        count                  <= count - 1'b1;
                    end
                    act_wr_kv_reg <= 1'b0;
                    act_wr_v_reg  <= 1'b0;
                    act_del_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Key/value storage writes, committed in the response cycle only.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == RESP) begin
            if (act_wr_kv_reg) key_mem[act_idx_reg] <= key_reg;
            if (act_wr_kv_reg || act_wr_v_reg) val_mem[act_idx_reg] <= value_reg;
        end
    end

`ifdef HT_STATS_EN
    // Saturating lookup hit/miss counters, bumped on each lookup response.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_reg == RESP && !is_insert && !is_delete) begin
            if (resp_status == ST_OK && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (resp_status == ST_NOT_FOUND && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/hash_table_probe.md
Name: hash_table_probe

Overview:
- Parametrised successor to the single-slot direct-mapped key/value table.
- Adds open addressing with linear probing, delete with tombstones, a valid/ready request handshake, a response channel with status codes, and an occupancy count.
- Sits beside the lookup pipeline as the key/value store.
- Services one operation at a time; probes one slot per cycle.

Parameters:
- KEY_WIDTH, 32: key width in bits.
- VALUE_WIDTH, 32: value width in bits.
- TABLE_SIZE, 16: number of slots; must be a power of two.
- INDEX_WIDTH, 4: log2(TABLE_SIZE).
- MAX_PROBE, 16: maximum slots examined per operation; 1 <= MAX_PROBE <= TABLE_SIZE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request present.
- op_ready  out  1  block can accept a request (high only in IDLE).
- op_code  in  2  00 = LOOKUP, 01 = INSERT, 10 = DELETE, 11 = reserved (treated as LOOKUP).
- op_key  in  KEY_WIDTH  request key.
- op_value  in  VALUE_WIDTH  insert value; ignored for other ops.
- resp_valid  out  1  one-cycle response pulse.
- resp_found  out  1  key was present when the operation started.
- resp_value  out  VALUE_WIDTH  stored value (lookup hit, or pre-delete/pre-update value); else 0.
- resp_status  out  2  00 = OK, 01 = NOT_FOUND, 10 = FULL.
- count  out  INDEX_WIDTH+1  number of live (valid, non-tombstone) slots.

Behaviour:
- Reset:
  - Clears every slot's valid and tombstone bits; key/value storage is not cleared.
  - Drives all outputs to 0 except op_ready, which is 1 in the first cycle after reset.
  - FSM enters IDLE.
  - Reset during PROBE or RESP aborts the operation: no table write, no resp_valid.
- Hash: h = XOR fold of op_key in INDEX_WIDTH-bit chunks, LSB chunk first; the top chunk is zero-padded. Probe slot k is (h + k) mod TABLE_SIZE, wrapping naturally.
- Handshake:
  - Accept on op_valid && op_ready in IDLE.
  - Key, value and opcode are latched at accept; later changes on the inputs have no effect.
- FSM:
  - IDLE -> PROBE on accept.
  - PROBE examines one slot per cycle and moves to RESP on termination.
  - RESP asserts resp_valid for exactly one cycle, then returns to IDLE.
  - op_ready is 0 in PROBE and RESP.
- Latency: accept in cycle T; slot k is examined in cycle T+1+k; resp_valid in the cycle after the terminating probe. Minimum latency is 2 cycles.
- Probe termination:
  - Key match on a valid slot.
  - An empty slot (neither valid nor tombstone).
  - MAX_PROBE slots examined.
  - Tombstones never terminate a probe.
- LOOKUP:
  - Match: found = 1, value = stored value, status OK.
  - Otherwise: found = 0, value = 0, status NOT_FOUND.
- INSERT:
  - Match: overwrite the value in place; found = 1, resp_value = old value, status OK, count unchanged.
  - No match: write to the first tombstone or empty slot seen during the probe; found = 0, status OK, count + 1.
  - No free slot seen: no write, status FULL.
  - The table write occurs in the RESP cycle.
- DELETE:
  - Match: clear valid and set tombstone; found = 1, resp_value = old value, status OK, count - 1.
  - No match: status NOT_FOUND.
- count never exceeds TABLE_SIZE; a full table returns FULL without modification.
- resp_found, resp_value and resp_status hold their values until the next response.

Optional Feature:
- Macro: HT_STATS_EN.
- When defined, adds outputs hit_count (32 bits) and miss_count (32 bits):
  - They count LOOKUP responses with status OK and NOT_FOUND respectively.
  - Both saturate at all-ones and clear on rst.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- After rst: LOOKUP key 0x5 accepted at T -> resp_valid at T+2, found = 0, status 01, value 0, count 0.
- INSERT key 0x3, value 0xAAAA, then LOOKUP 0x3 -> insert response found = 0, status 00; lookup found = 1, value 0xAAAA; count 1.
- Collision: INSERT 0x3 = 1, then INSERT 0x120 = 2 (hash 3) -> 0x120 lands in slot 4; LOOKUP 0x120 accepted at T -> resp_valid at T+3, value 2.
- Tombstone: after the collision test, DELETE 0x3 -> found = 1, value 1, count 1; LOOKUP 0x120 still hits with value 2; re-INSERT 0x3 reuses slot 3, count 2.
- Full: insert 16 distinct keys -> count 16; 17th new key -> status 10, count 16; INSERT of an existing key still updates with status 00.
- Assert rst in the cycle after accepting an INSERT -> no resp_valid, count 0, op_ready 1 next cycle; with HT_STATS_EN, two hits and one miss -> hit_count 2, miss_count 1.
